// File: rtl/cpu_control_unit_pkg.sv
// Shared constants for the multi-cycle control unit.
// Opcodes, FSM state encodings and ALU operation selects.
package cpu_control_unit_pkg;

    localparam int DATA_BUS_WIDTH = 16;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_BEQZ = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_OP_ADD = 3'd0;
    localparam logic [2:0] ALU_OP_SUB = 3'd1;
    localparam logic [2:0] ALU_OP_AND = 3'd2;
    localparam logic [2:0] ALU_OP_OR  = 3'd3;
    localparam logic [2:0] ALU_OP_XOR = 3'd4;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

endpackage

// File: rtl/cpu_control_unit_decoder.sv
// Combinational opcode decoder for the control unit.
// Unlisted opcodes decode as NOP (no flags set, ALU_OP_ADD).
module cu_decoder
    import cpu_control_unit_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] alu_op,
    output logic       is_alu,
    output logic       is_beqz,
    output logic       is_jmp,
    output logic       is_halt
);

    always_comb begin
        alu_op  = ALU_OP_ADD;
        is_alu  = 1'b0;
        is_beqz = 1'b0;
        is_jmp  = 1'b0;
        is_halt = 1'b0;
        unique case (1'b1)
            (opcode == OP_ADD):  is_alu = 1'b1;
            (opcode == OP_SUB): begin
                is_alu = 1'b1;
                alu_op = ALU_OP_SUB;
            end
            (opcode == OP_BEQZ): is_beqz = 1'b1;
            (opcode == OP_JMP):  is_jmp = 1'b1;
            (opcode == OP_HALT): is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback control unit.
// Drives register-file addresses and ALU op; tracks the Z flag.
module cpu_control_unit #(
    parameter int DATA_BUS_WIDTH = cpu_control_unit_pkg::DATA_BUS_WIDTH,
    parameter int ADDR_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [ADDR_WIDTH-1:0]     imem_addr,
    output logic                      imem_req,
    input  logic                      imem_ack,
    input  logic [DATA_BUS_WIDTH-1:0] imem_rdata,
    output logic [3:0]                rf_ra_addr,
    output logic [3:0]                rf_rb_addr,
    output logic [3:0]                rf_wa,
    output logic                      rf_we,
    output logic [2:0]                alu_op,
    input  logic                      alu_z,
    output logic                      z_flag,
    output logic                      halted
);

    import cpu_control_unit_pkg::*;

    state_t                    state;
    logic [ADDR_WIDTH-1:0]     pc;
    logic [DATA_BUS_WIDTH-1:0] ir;

    logic [2:0] dec_alu_op;
    logic       dec_is_alu;
    logic       dec_is_beqz;
    logic       dec_is_jmp;
    logic       dec_is_halt;

    logic [ADDR_WIDTH-1:0] br_tgt;
    logic [ADDR_WIDTH-1:0] jmp_tgt;

    cu_decoder u_dec (
        .opcode  (ir[15:12]),
        .alu_op  (dec_alu_op),
        .is_alu  (dec_is_alu),
        .is_beqz (dec_is_beqz),
        .is_jmp  (dec_is_jmp),
        .is_halt (dec_is_halt)
    );

    assign imem_addr  = pc;
    assign rf_ra_addr = ir[7:4];
    assign rf_rb_addr = ir[3:0];
    assign rf_wa      = ir[11:8];

    // pc already points past the branch when this is used
    assign br_tgt  = pc + ADDR_WIDTH'($signed(ir[7:0]));
    assign jmp_tgt = ADDR_WIDTH'(ir[7:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            pc       <= '0;
            ir       <= '0;
            z_flag   <= 1'b0;
            halted   <= 1'b0;
            rf_we    <= 1'b0;
            alu_op   <= ALU_OP_ADD;
            imem_req <= 1'b1;
        end else begin
            rf_we <= 1'b0;
            unique case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        pc       <= pc + ADDR_WIDTH'(1);
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_op <= dec_alu_op;
                    unique case (1'b1)
                        dec_is_alu: state <= S_EXECUTE;
                        dec_is_halt: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: begin
                            if (dec_is_jmp)
                                pc <= jmp_tgt;
                            else if (dec_is_beqz && z_flag)
                                pc <= br_tgt;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    endcase
                end
                S_EXECUTE: begin
                    rf_we <= 1'b1;
                    state <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    z_flag   <= alu_z;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: ;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Randomized instruction-level bench for cpu_control_unit.
// Reference model tracks pc and Z per instruction and checks timing.
module tb_cpu_control_unit;

    import cpu_control_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [3:0]  rf_ra_addr;
    logic [3:0]  rf_rb_addr;
    logic [3:0]  rf_wa;
    logic        rf_we;
    logic [2:0]  alu_op;
    logic        alu_z;
    logic        z_flag;
    logic        halted;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_pc;
    logic       m_z;

    always #5 clk = ~clk;

    cpu_control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .rf_ra_addr (rf_ra_addr),
        .rf_rb_addr (rf_rb_addr),
        .rf_wa      (rf_wa),
        .rf_we      (rf_we),
        .alu_op     (alu_op),
        .alu_z      (alu_z),
        .z_flag     (z_flag),
        .halted     (halted)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Inputs outside FETCH/WRITEBACK must be ignored, so scramble them
    task automatic noise();
        imem_ack   = 1'($urandom);
        imem_rdata = 16'($urandom);
        alu_z      = 1'($urandom);
    endtask

    task automatic check_reset();
        check("rst_req", imem_req, 1);
        check("rst_addr", imem_addr, 0);
        check("rst_z", z_flag, 0);
        check("rst_halt", halted, 0);
        check("rst_we", rf_we, 0);
        check("rst_aluop", alu_op, ALU_OP_ADD);
        check("rst_ra", rf_ra_addr, 0);
        check("rst_rb", rf_rb_addr, 0);
    endtask

    task automatic fetch_idle();
        check("f_req", imem_req, 1);
        check("f_addr", imem_addr, m_pc);
        check("f_z", z_flag, m_z);
        check("f_halt", halted, 0);
        check("f_we", rf_we, 0);
    endtask

    // Starts at a negedge in FETCH, ends at the negedge in DECODE
    task automatic fetch(input logic [15:0] instr, input int waits);
        for (int i = 0; i < waits; i++) begin
            fetch_idle();
            imem_ack   = 1'b0;
            imem_rdata = 16'($urandom);
            alu_z      = 1'($urandom);
            @(negedge clk);
        end
        fetch_idle();
        imem_ack   = 1'b1;
        imem_rdata = instr;
        alu_z      = 1'($urandom);
        @(negedge clk);
        m_pc = m_pc + 8'd1;
    endtask

    task automatic run_instr(input logic [15:0] instr, input int waits,
                             input logic z);
        int op;
        int off;
        logic [2:0] exp_op;
        fetch(instr, waits);
        op = int'(instr[15:12]);
        check("d_req", imem_req, 0);
        check("d_we", rf_we, 0);
        noise();
        @(negedge clk);
        if (op == 1 || op == 2) begin
            exp_op = (op == 2) ? ALU_OP_SUB : ALU_OP_ADD;
            check("ex_aluop", alu_op, exp_op);
            check("ex_we", rf_we, 0);
            check("ex_req", imem_req, 0);
            check("ex_ra", rf_ra_addr, instr[7:4]);
            check("ex_rb", rf_rb_addr, instr[3:0]);
            check("ex_z", z_flag, m_z);
            noise();
            @(negedge clk);
            check("wb_we", rf_we, 1);
            check("wb_wa", rf_wa, instr[11:8]);
            check("wb_aluop", alu_op, exp_op);
            check("wb_req", imem_req, 0);
            noise();
            alu_z = z;
            @(negedge clk);
            m_z = z;
        end else if (op == 3) begin
            if (m_z) begin
                off  = int'($signed(instr[7:0]));
                m_pc = 8'(int'(m_pc) + off + 256);
            end
        end else if (op == 4) begin
            m_pc = instr[7:0];
        end else if (op == 15) begin
            for (int i = 0; i < 6; i++) begin
                check("h_halt", halted, 1);
                check("h_req", imem_req, 0);
                check("h_we", rf_we, 0);
                noise();
                @(negedge clk);
            end
        end
        imem_ack = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        alu_z      = 1'b0;
        m_pc       = 8'd0;
        m_z        = 1'b0;
        repeat (2) @(negedge clk);
        check_reset();
        rst_n = 1'b1;

        run_instr(16'h1123, 0, 1'b0);
        run_instr(16'h2455, 0, 1'b1);
        run_instr(16'h0000, 0, 1'b0);
        run_instr(16'h0000, 1, 1'b0);
        run_instr(16'h7ABC, 0, 1'b0);
        check("br_pc", imem_addr, 5);
        run_instr(16'h30FC, 0, 1'b0);
        check("br_taken", imem_addr, 2);
        run_instr(16'h2455, 0, 1'b0);
        run_instr(16'h30FC, 0, 1'b0);
        check("br_not", imem_addr, 4);
        run_instr(16'h40FF, 0, 1'b0);
        check("jmp_ff", imem_addr, 255);
        run_instr(16'h0000, 3, 1'b0);
        check("wrap", imem_addr, 0);

        for (int n = 0; n < 200; n++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 14));
            run_instr({op, 12'($urandom)}, $urandom_range(0, 3),
                      1'($urandom));
        end

        run_instr(16'h2455, 0, 1'b1);
        fetch(16'h2123, 0);
        noise();
        @(negedge clk);
        check("ar_aluop", alu_op, ALU_OP_SUB);
        imem_ack = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset();
        @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        m_pc  = 8'd0;
        m_z   = 1'b0;
        run_instr(16'h1123, 2, 1'b1);
        run_instr(16'hF000, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
Multi-cycle control unit sitting directly upstream of the ALU. Fetches 16-bit instructions over a req/ack instruction-memory handshake, decodes them, and drives the register-file addresses, the ALU operation select and the write enable. Captures the ALU zero output into an architectural Z flag. Executes PC-relative branch-if-zero, absolute jump and halt.

Parameters:
DATA_BUS_WIDTH, 16, instruction and data word width (shared params value)
ADDR_WIDTH, 8, program counter / instruction address width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  ADDR_WIDTH  instruction fetch address (= pc)
imem_req  output  1  fetch request
imem_ack  input  1  fetch data valid; may assert the same cycle as imem_req
imem_rdata  input  DATA_BUS_WIDTH  instruction word, valid when imem_ack=1
rf_ra_addr  output  4  register-file read port A address (ALU operand A)
rf_rb_addr  output  4  register-file read port B address (ALU operand B)
rf_wa  output  4  register-file write address
rf_we  output  1  register-file write enable, ALU result as write data
alu_op  output  3  ALU operation select (ALU_OP_* encodings)
alu_z  input  1  ALU zero output for the current operands/op
z_flag  output  1  architectural zero flag
halted  output  1  high while in HALT

Behaviour:
- Reset: one clock, asynchronous active-low reset; all state clears immediately when rst_n falls, including mid-fetch or mid-execute.
- Reset values: pc=0, IR=0, state=FETCH, z_flag=0, halted=0, rf_we=0, alu_op=ALU_OP_ADD.
- Instruction format: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt; imm8 = [7:0].
- Opcodes: 0 NOP; 1 ADD rd=rs+rt; 2 SUB rd=rs-rt; 3 BEQZ, taken if z_flag=1: pc=pc+sext(imm8); 4 JMP pc=imm8; F HALT. Opcodes 5..E execute as NOP.
- FETCH: imem_req=1, imem_addr=pc. On a clock edge with imem_ack=1: IR<=imem_rdata, pc<=pc+1 (wraps modulo 2^ADDR_WIDTH), go to DECODE. Otherwise hold; wait states are unbounded.
- DECODE:
  - ADD/SUB -> EXECUTE.
  - BEQZ: taken -> pc<=pc+sext(imm8); not taken -> no pc change; then FETCH. pc here is already the incremented value; the sum wraps modulo 2^ADDR_WIDTH.
  - JMP: pc<=imm8 (zero-extended), then FETCH.
  - NOP/illegal -> FETCH.
  - HALT -> HALT.
- EXECUTE: alu_op driven from the decoded opcode; operands settle. Go to WRITEBACK.
- WRITEBACK: rf_we=1 for exactly this cycle, rf_wa=rd; z_flag<=alu_z on this edge. Then FETCH.
- HALT: halted=1, imem_req=0, rf_we=0. Only rst_n exits.
- rf_ra_addr=IR[7:4] and rf_rb_addr=IR[3:0] continuously. alu_op is held stable through EXECUTE and WRITEBACK; ADD->ALU_OP_ADD, SUB->ALU_OP_SUB, otherwise ALU_OP_ADD.
- imem_req is 0 outside FETCH. imem_ack outside FETCH is ignored.
- z_flag changes only in WRITEBACK of ADD/SUB; branches, jumps and NOPs preserve it.
- Latency with zero-wait memory: ADD/SUB 4 cycles, BEQZ/JMP/NOP 2 cycles. Each memory wait cycle adds 1.

Decomposition:
- Shared params package: opcode constants (OP_NOP, OP_ADD, OP_SUB, OP_BEQZ, OP_JMP, OP_HALT), state encodings (S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT), and the existing ALU_OP_* and DATA_BUS_WIDTH values.
- One combinational sub-module, cu_decoder: opcode -> {alu_op, is_alu, is_beqz, is_jmp, is_halt}.

Test Plan:
- Reset then ADD: release rst_n; imem_rdata=16'h1123 acked immediately -> imem_addr=0; DECODE next cycle; alu_op=ALU_OP_ADD in cycles 3-4; rf_we=1 only in cycle 4 with rf_wa=1, ra=2, rb=3; pc=1.
- SUB sets Z: 16'h2455 with alu_z=1 in WRITEBACK -> z_flag=1. A following NOP leaves z_flag=1.
- Branch: z_flag=1 at pc=5, instruction 16'h30FC -> next fetch address 6-4=2. With z_flag=0 -> next fetch address 6.
- Wrap and jump: JMP 16'h40FF -> fetch address 255; its ack -> pc wraps to 0.
- Wait states: imem_ack low 3 cycles -> imem_req held, imem_addr stable, no state advance. Ack on cycle 4 -> DECODE.
- HALT/reset: 16'hF000 -> halted=1, imem_req=0 indefinitely. rst_n low mid-EXECUTE -> immediate return to reset values without waiting for clk.
